// File: rtl/alu_pkg.sv
// Shared opcode codes and sequencer state encoding for the bit-serial alu path.
package alu_pkg;

  // 4-bit {mode,opcode} codes understood by the 1-bit alu stage
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_XNOR = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_ADD1 = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_op_map.sv
// Maps the requested operation to the alu code for the current bit.
// The alu has no carry-in, so the registered carry selects between the
// "no carry" and "carry" flavour of the op for every bit after bit 0.
module serial_op_map
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       first,
  input  logic       c,
  output logic [1:0] alu_mode,
  output logic [1:0] alu_opcode,
  output logic       chain_en,
  output logic       supported
);

  logic [3:0] code;

  // Per-bit code selection and support decode
  always_comb begin
    code      = 4'b0000;
    chain_en  = 1'b0;
    supported = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_XNOR: begin
        code      = op;
        supported = 1'b1;
      end
      OP_PASS: begin
        code      = OP_PASS;
        supported = 1'b1;
      end
      OP_ADD: begin
        code      = (first || !c) ? OP_ADD : OP_ADD1;
        chain_en  = 1'b1;
        supported = 1'b1;
      end
      OP_ADD1: begin
        code      = (first || c) ? OP_ADD1 : OP_ADD;
        chain_en  = 1'b1;
        supported = 1'b1;
      end
      OP_INC: begin
        code      = (first || c) ? OP_INC : OP_PASS;
        chain_en  = 1'b1;
        supported = 1'b1;
      end
      default: ;
    endcase
  end

  assign {alu_mode, alu_opcode} = code;

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: streams a/b LSB-first through an external 1-bit alu,
// chains the carry via per-bit opcode choice and reassembles the result word.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; unsupported ops pulse err
//   ST_RUN   | one operand bit per cycle through the alu, WIDTH cycles
//   ST_DONE  | result/cout updated, done pulses for this single cycle
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [1:0]       alu_mode,
  output logic [1:0]       alu_opcode,
  output logic             alu_ain,
  output logic             alu_bin,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [3:0] op_sel;
  logic [1:0] map_mode;
  logic [1:0] map_opcode;
  logic       map_chain_en;
  logic       map_supported;

  // In IDLE the map only judges the incoming request; in RUN it drives the alu
  assign op_sel = (state_q == ST_IDLE) ? {mode, opcode} : op_q;

  serial_op_map u_op_map (
    .op         (op_sel),
    .first      (cnt_q == '0),
    .c          (c_q),
    .alu_mode   (map_mode),
    .alu_opcode (map_opcode),
    .chain_en   (map_chain_en),
    .supported  (map_supported)
  );

  // Next-state, datapath and alu drive
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    result_d   = result_q;
    cout_d     = cout_q;
    err_d      = 1'b0;
    alu_mode   = 2'b00;
    alu_opcode = 2'b00;
    alu_ain    = 1'b0;
    alu_bin    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (map_supported) begin
            state_d  = ST_RUN;
            op_d     = {mode, opcode};
            a_sh_d   = a;
            b_sh_d   = b;
            res_sh_d = '0;
            cnt_d    = '0;
            c_d      = 1'b0;
            result_d = '0;
            cout_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        alu_mode   = map_mode;
        alu_opcode = map_opcode;
        alu_ain    = a_sh_q[0];
        alu_bin    = b_sh_q[0];
        res_sh_d   = WIDTH'({alu_result, res_sh_q} >> 1);
        a_sh_d     = a_sh_q >> 1;
        b_sh_d     = b_sh_q >> 1;
        cnt_d      = cnt_q + CW'(1);
        // alu_cout is undefined for logic ops, so it is only taken when chaining
        c_d        = map_chain_en ? alu_cout : 1'b0;
        if (cnt_q == LAST_BIT) begin
          state_d  = ST_DONE;
          result_d = res_sh_d;
          cout_d   = c_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with a behavioural 1-bit alu attached.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode, opcode;
  logic [W-1:0] a, b;
  logic         busy, done, err, cout;
  logic [W-1:0] result;
  logic [1:0]   alu_mode, alu_opcode;
  logic         alu_ain, alu_bin, alu_result, alu_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .cout       (cout),
    .alu_mode   (alu_mode),
    .alu_opcode (alu_opcode),
    .alu_ain    (alu_ain),
    .alu_bin    (alu_bin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  // 1-bit alu stage: logic ops, pass, a+b, a+b+1, a+1 (no carry-in port)
  always_comb begin
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    case ({alu_mode, alu_opcode})
      4'b0000: begin alu_result = alu_ain & alu_bin;    alu_cout = 1'bx; end
      4'b0001: begin alu_result = alu_ain | alu_bin;    alu_cout = 1'bx; end
      4'b0010: begin alu_result = alu_ain ^ alu_bin;    alu_cout = 1'bx; end
      4'b0011: begin alu_result = ~(alu_ain ^ alu_bin); alu_cout = 1'bx; end
      4'b0100: begin alu_result = alu_ain;              alu_cout = 1'b0; end
      4'b0110: begin alu_result = alu_ain ^ alu_bin;    alu_cout = alu_ain & alu_bin; end
      4'b1010: begin alu_result = ~(alu_ain ^ alu_bin); alu_cout = alu_ain | alu_bin; end
      4'b1000: begin alu_result = ~alu_ain;             alu_cout = alu_ain; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation end to end; optionally pokes a second start mid-RUN
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] er, input logic ec, input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1;
    {mode, opcode} = op;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia;
    b = ib ^ 8'h5A;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      if (poke && n == 3) begin
        start = 1'b1;
        {mode, opcode} = 4'b0110;
        a = 8'h01;
        b = 8'h01;
      end
      if (poke && n == 4) start = 1'b0;
      if (done) break;
    end
    check({tag, ".latency"}, n, 32'd9);
    check({tag, ".result"}, {24'd0, result}, {24'd0, er});
    check({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    @(negedge clk);
    check({tag, ".done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    opcode = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.flags", {29'd0, busy, done, err}, 32'd0);
    check("rst.result", {23'd0, result, cout}, 32'd0);
    check("rst.alu", {26'd0, alu_mode, alu_opcode, alu_ain, alu_bin}, 32'd0);

    run_op("add",     4'b0110, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op("add_ovf", 4'b0110, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add1",    4'b1010, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0);
    run_op("add1_ov", 4'b1010, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("inc_ff",  4'b1000, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("inc_0f",  4'b1000, 8'h0F, 8'h00, 8'h10, 1'b0, 1'b0);
    run_op("pass",    4'b0100, 8'hC3, 8'hFF, 8'hC3, 1'b0, 1'b0);
    run_op("and",     4'b0000, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0);
    run_op("xor",     4'b0010, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0);

    // unsupported op: err pulse, no RUN, result untouched
    @(negedge clk);
    start = 1'b1;
    {mode, opcode} = 4'b0111;
    a = 8'hFF;
    b = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("unsup.err", {30'd0, err, busy}, 32'd2);
    @(negedge clk);
    check("unsup.err_pulse", {30'd0, err, busy}, 32'd0);
    check("unsup.result", {24'd0, result}, 32'h5A);

    // start during RUN must be ignored
    run_op("add_poke", 4'b0110, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
    @(negedge clk);
    check("poke.no_requeue", {31'd0, busy}, 32'd0);

    // reset mid-RUN aborts without done
    @(negedge clk);
    start = 1'b1;
    {mode, opcode} = 4'b0110;
    a = 8'h77;
    b = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort.busy", {30'd0, busy, done}, 32'd0);
    check("abort.result", {23'd0, result, cout}, 32'd0);
    check("abort.alu", {26'd0, alu_mode, alu_opcode, alu_ain, alu_bin}, 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort.no_done", {31'd0, saw_done}, 32'd0);

    run_op("or_after", 4'b0001, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
